rnd_pair_expander: RTL



---
 rtl/rnd_pair_expander.sv | 129 ++++++++++++
 1 files changed

// File: rtl/rnd_pair_expander.sv
// rnd_pair_expander
// Takes one RNDSIZE-bit raw random word per frame and expands it into the
// RW = RNDSIZE*(RNDSIZE-1)/2 pairwise XOR bits used by the segment random
// switch. Pair k enumerates (i,j), i<j, i-major, and out_r[k] = a[i] ^ a[j].
// Each EXPAND cycle produces up to PPC pairs. Valid/ready handshakes on both
// sides decouple the RNG source from the frame consumer.
module rnd_pair_expander #(
    parameter int RNDSIZE = 8,
    parameter int PPC     = 4,
    // Derived output width; kept local so it always tracks RNDSIZE.
    localparam int RW     = RNDSIZE * (RNDSIZE - 1) / 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [RNDSIZE-1:0] in_rnd,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [RW-1:0]      out_r,
    output logic               busy
);

    // k must be able to hold RW itself, the value reached after the last step.
    localparam int KW = (RW < 2) ? 1 : $clog2(RW + 1);
    // i/j must be able to hold RNDSIZE, reached when the walk runs off the end.
    localparam int IW = $clog2(RNDSIZE + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t              state_q;
    logic [RNDSIZE-1:0]  a_q;
    logic [RW-1:0]       r_q;
    logic [RW-1:0]       r_d;
    logic [KW-1:0]       k_q;
    logic [KW-1:0]       k_d;
    logic [IW-1:0]       i_q;
    logic [IW-1:0]       i_d;
    logic [IW-1:0]       j_q;
    logic [IW-1:0]       j_d;
    logic                out_valid_q;
    logic                in_ready_q;
    logic                busy_q;

    // One EXPAND step: write up to PPC pairs starting at k, stop at RW.
    always_comb begin
        r_d = r_q;
        k_d = k_q;
        i_d = i_q;
        j_d = j_q;
        for (int p = 0; p < PPC; p++) begin
            if (int'(k_d) < RW) begin
                r_d[k_d] = a_q[i_d] ^ a_q[j_d];
                k_d      = k_d + KW'(1);
                if (j_d == IW'(RNDSIZE - 1)) begin
                    // End of row i: the next row starts at (i+1, i+2).
                    i_d = i_d + IW'(1);
                    j_d = i_d + IW'(1);
                end else begin
                    j_d = j_d + IW'(1);
                end
            end
        end
    end

    // Control FSM with registered handshake/status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            r_q         <= '0;
            k_q         <= '0;
            i_q         <= '0;
            j_q         <= IW'(1);
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= in_rnd;
                        r_q        <= '0;
                        k_q        <= '0;
                        i_q        <= '0;
                        j_q        <= IW'(1);
                        state_q    <= EXPAND;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                EXPAND: begin
                    r_q <= r_d;
                    k_q <= k_d;
                    i_q <= i_d;
                    j_q <= j_d;
                    if (k_d == KW'(RW)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    // r_q is left alone so out_r holds until the next accept.
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign out_r     = r_q;
    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;
    assign busy      = busy_q;

endmodule
